// File: rtl/clk_div_prog.sv
`default_nettype none
// ============================================================================
//  Module   : clk_div_prog
//  Brief    : Runtime-programmable integer clock divider (1 .. 2^W-1) with a
//             period-start tick and boundary-synchronised divisor updates.
//  Revision : 1.0
// ============================================================================
module clk_div_prog #(
    parameter int             W           = 8,
    parameter logic [W-1:0]   DEFAULT_DIV = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic         div_wr,
    input  logic [W-1:0] div_in,
    output logic         clk_out,
    output logic         tick,
    output logic         pending,
    output logic [W-1:0] cur_div
);

    localparam logic [W-1:0] c_one  = {{(W-1){1'b0}}, 1'b1};
    localparam logic [W-1:0] c_zero = '0;

    logic [W-1:0] r_cnt;
    logic         r_running;
    logic [W-1:0] r_cur_div;
    logic [W-1:0] r_pend_div;
    logic         r_pending;
    logic         r_clk_out;
    logic         r_tick;

    logic         w_last;
    logic         w_apply;
    logic         w_wr_ok;
    logic [W-1:0] w_eff_div;
    logic [W-1:0] w_high;
    logic [W-1:0] w_cnt_next;

    assign w_wr_ok = div_wr && (div_in != c_zero);
    assign w_last  = (r_cnt == (r_cur_div - c_one));

    // A pending divisor takes effect at a wrap, at start, or whenever idle.
    always_comb begin
        w_apply = 1'b0;
        if (r_pending) begin
            if (!en || !r_running || w_last) begin
                w_apply = 1'b1;
            end
        end
    end

    assign w_eff_div  = w_apply ? r_pend_div : r_cur_div;
    // ceil(N/2) without an extra bit: N/2 + lsb(N).
    assign w_high     = {1'b0, w_eff_div[W-1:1]} + {{(W-1){1'b0}}, w_eff_div[0]};
    assign w_cnt_next = w_last ? c_zero : (r_cnt + c_one);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt      <= c_zero;
            r_running  <= 1'b0;
            r_cur_div  <= DEFAULT_DIV;
            r_pend_div <= DEFAULT_DIV;
            r_pending  <= 1'b0;
            r_clk_out  <= 1'b0;
            r_tick     <= 1'b0;
        end else begin
            if (w_apply) begin
                r_cur_div <= r_pend_div;
                r_pending <= 1'b0;
            end
            // A write on an applying edge stays pending for the next boundary.
            if (w_wr_ok) begin
                r_pend_div <= div_in;
                r_pending  <= 1'b1;
            end

            if (!en) begin
                r_running <= 1'b0;
                r_cnt     <= c_zero;
                r_clk_out <= 1'b0;
                r_tick    <= 1'b0;
            end else if (!r_running) begin
                r_running <= 1'b1;
                r_cnt     <= c_zero;
                r_clk_out <= 1'b1;
                r_tick    <= 1'b1;
            end else begin
                r_cnt     <= w_cnt_next;
                r_clk_out <= (w_cnt_next < w_high);
                r_tick    <= (w_cnt_next == c_zero);
            end
        end
    end

    assign clk_out = r_clk_out;
    assign tick    = r_tick;
    assign pending = r_pending;
    assign cur_div = r_cur_div;

endmodule
`default_nettype wire

// File: doc/clk_div_prog.md
Name: clk_div_prog

Overview:
- Parametrised successor to the fixed divide-by-2 block: runtime-programmable integer clock divider (divide by 1 to 2^W-1).
- Generates a registered divided waveform and a one-cycle period-start tick.
- Divisor updates are glitch-free: they are applied only at a period boundary.
- Sits in the clocking/timebase layer and feeds slow-domain enables, with clk_out usable as a derived clock.

Parameters:
- W, 8, width of divisor and internal counter.
- DEFAULT_DIV, 2, divisor loaded at reset (range 1..2^W-1); default gives divide-by-2 compatibility.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- en  input  1  run enable.
- div_wr  input  1  one-cycle strobe that captures div_in as the pending divisor.
- div_in  input  W  requested divisor N.
- clk_out  output  1  registered divided waveform.
- tick  output  1  registered one-cycle pulse, high in the same cycle clk_out begins a new period.
- pending  output  1  a written divisor is waiting for a period boundary.
- cur_div  output  W  divisor currently in effect.

Behaviour:
- Reset (async, rst=1): cnt=0, running=0, cur_div=DEFAULT_DIV, pend_div=DEFAULT_DIV, pending=0, clk_out=0, tick=0.
- Notation: N=cur_div, H=ceil(N/2) high cycles per period, N-H low cycles.
- Start: first edge with en=1 while running=0 sets cnt=0, running=1, clk_out=1, tick=1. This is 1-cycle latency from en.
- Run (en=1, running=1), each edge:
  - cnt_next = (cnt==N-1) ? 0 : cnt+1.
  - clk_out <= (cnt_next < H).
  - tick <= (cnt_next==0).
- Period: N cycles. N even gives 50% duty. N odd gives high for (N+1)/2 cycles and low for (N-1)/2 cycles.
- N=1: clk_out stays 1 and tick=1 every cycle.
- Boundary: an edge where cnt==N-1 wraps cnt to 0.
  - If pending=1 on that edge: cur_div<=pend_div, pending<=0.
  - H for that same edge's clk_out is computed from the new divisor, so the new period starts with the new ratio.
- div_wr:
  - Captures div_in into pend_div and sets pending=1 on the next edge.
  - div_in==0 is ignored: no capture, pending unchanged.
  - Back-to-back writes: last write wins.
- div_wr on the boundary edge: the boundary applies the pend_div held before that edge. The newly written value stays pending until the next boundary.
- en=0: next edge sets running=0, cnt=0, clk_out=0, tick=0.
  - If pending=1 while en=0: cur_div<=pend_div, pending<=0 on that edge (immediate apply).
  - Re-enable restarts a fresh period via Start; no partial period resumes.
- Reset mid-period: all state returns to reset values immediately. Any pending divisor is discarded.
- Width: cnt is W bits. N-1 and H are computed in W bits with no overflow, since N ≤ 2^W-1.
- No combinational path from inputs to outputs. clk_out and tick are flop outputs, so they are glitch-free.

Test Plan:
- Default ratio: clk 10 ns period, rst=1 for 50 ns, en=1 -> clk_out period 20 ns (1 high, 1 low), tick every 2nd cycle, cur_div=2; matches legacy divide-by-2.
- Odd ratio: write 3 while en=0, then en=1 -> cur_div=3, pending=0, clk_out pattern 1,1,0 repeating, tick on each clk_out rise.
- Mid-period change: running N=4, write 5 at cnt=1 -> pending=1 until the cnt 3->0 edge. The next period is 1,1,1,0,0; no runt pulse.
- Boundary collision and rejects:
  - Write 6 at cnt==N-1 with no prior pending -> current ratio continues one more period, then 6 applies.
  - div_in=0 write -> ignored, pending stays 0.
- N=1 and enable gating: N=1 -> clk_out held 1, tick every cycle. en drop -> clk_out=0 next edge. en rise -> clk_out=1, tick=1 one edge later.
- Async reset mid-run: assert rst between clock edges with pending=1 -> outputs clear immediately, cur_div=2, pending=0.
